// File: rtl/dpram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the A/B ports of a registered dual-port RAM.
// Read data returns 2 cycles after gnt; requesters hold req until gnt, and an address hazard on port B defers that request.
module dpram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rdata,
  output logic [ADDR_WIDTH-1:0]            ram_addr_a,
  output logic [ADDR_WIDTH-1:0]            ram_addr_b,
  output logic [DATA_WIDTH-1:0]            ram_data_a,
  output logic [DATA_WIDTH-1:0]            ram_data_b,
  output logic                             ram_we_a,
  output logic                             ram_we_b,
  input  logic [DATA_WIDTH-1:0]            ram_out_a,
  input  logic [DATA_WIDTH-1:0]            ram_out_b,
  output logic [15:0]                      conflict_cnt
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef logic [IDW-1:0] id_t;
  typedef struct packed {
    logic vld;
    logic rd;
    id_t  id;
  } tag_t;

  function automatic id_t wrap_inc(input id_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return id_t'(s);
  endfunction

  id_t                          rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]        ram_addr_a_q, ram_addr_a_d, ram_addr_b_q, ram_addr_b_d;
  logic [DATA_WIDTH-1:0]        ram_data_a_q, ram_data_a_d, ram_data_b_q, ram_data_b_d;
  logic                         ram_we_a_q, ram_we_a_d, ram_we_b_q, ram_we_b_d;
  tag_t                         tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [NUM_REQ-1:0]           rvalid_q, rvalid_d, rsel_q, rsel_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q, rdata_d, rdata_mux;
  logic [15:0]                  conflict_cnt_q, conflict_cnt_d;

  id_t                   cur, a_idx, b_idx;
  logic                  a_found, b_found, hazard, b_gnt;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [NUM_REQ-1:0]    gnt_raw;

  // Rotating search from rr: first pending request takes port A, the next one port B.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    cur     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cur = wrap_inc(rr_q, k);
      if (req[cur]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = cur;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = cur;
        end
      end
    end
    a_addr  = addr[int'(a_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    b_addr  = addr[int'(b_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    // Same-address pair involving a write would race inside the RAM, so B waits.
    hazard  = a_found && b_found && (a_addr == b_addr) && (we[a_idx] || we[b_idx]);
    b_gnt   = b_found && !hazard;
    gnt_raw = '0;
    if (a_found) gnt_raw[a_idx] = 1'b1;
    if (b_gnt)   gnt_raw[b_idx] = 1'b1;
  end

  assign gnt = rst ? '0 : gnt_raw;

  always_comb begin
    rr_d = rr_q;
    if (a_found) rr_d = wrap_inc(b_gnt ? b_idx : a_idx, 1);

    ram_addr_a_d = ram_addr_a_q;
    ram_data_a_d = ram_data_a_q;
    ram_we_a_d   = 1'b0;
    tag_a_d      = '0;
    if (a_found) begin
      ram_addr_a_d = a_addr;
      ram_data_a_d = wdata[int'(a_idx)*DATA_WIDTH +: DATA_WIDTH];
      ram_we_a_d   = we[a_idx];
      tag_a_d.vld  = 1'b1;
      tag_a_d.rd   = !we[a_idx];
      tag_a_d.id   = a_idx;
    end

    ram_addr_b_d = ram_addr_b_q;
    ram_data_b_d = ram_data_b_q;
    ram_we_b_d   = 1'b0;
    tag_b_d      = '0;
    if (b_gnt) begin
      ram_addr_b_d = b_addr;
      ram_data_b_d = wdata[int'(b_idx)*DATA_WIDTH +: DATA_WIDTH];
      ram_we_b_d   = we[b_idx];
      tag_b_d.vld  = 1'b1;
      tag_b_d.rd   = !we[b_idx];
      tag_b_d.id   = b_idx;
    end

    // Second tag stage: which requester gets a read return, and from which port.
    rvalid_d = '0;
    rsel_d   = '0;
    if (tag_a_q.vld && tag_a_q.rd) rvalid_d[tag_a_q.id] = 1'b1;
    if (tag_b_q.vld && tag_b_q.rd) begin
      rvalid_d[tag_b_q.id] = 1'b1;
      rsel_d[tag_b_q.id]   = 1'b1;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      rdata_mux[i*DATA_WIDTH +: DATA_WIDTH] = rvalid_q[i] ? (rsel_q[i] ? ram_out_b : ram_out_a)
                                                          : rdata_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    rdata_d = rdata_mux;

    conflict_cnt_d = conflict_cnt_q;
    if (hazard && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q           <= '0;
      ram_addr_a_q   <= '0;
      ram_addr_b_q   <= '0;
      ram_data_a_q   <= '0;
      ram_data_b_q   <= '0;
      ram_we_a_q     <= 1'b0;
      ram_we_b_q     <= 1'b0;
      tag_a_q        <= '0;
      tag_b_q        <= '0;
      rvalid_q       <= '0;
      rsel_q         <= '0;
      rdata_q        <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_q           <= rr_d;
      ram_addr_a_q   <= ram_addr_a_d;
      ram_addr_b_q   <= ram_addr_b_d;
      ram_data_a_q   <= ram_data_a_d;
      ram_data_b_q   <= ram_data_b_d;
      ram_we_a_q     <= ram_we_a_d;
      ram_we_b_q     <= ram_we_b_d;
      tag_a_q        <= tag_a_d;
      tag_b_q        <= tag_b_d;
      rvalid_q       <= rvalid_d;
      rsel_q         <= rsel_d;
      rdata_q        <= rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign ram_addr_a   = ram_addr_a_q;
  assign ram_addr_b   = ram_addr_b_q;
  assign ram_data_a   = ram_data_a_q;
  assign ram_data_b   = ram_data_b_q;
  assign ram_we_a     = ram_we_a_q;
  assign ram_we_b     = ram_we_b_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_mux;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a registered read-old dual-port RAM model.
module tb_dpram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     we = '0;
  logic [NR*AW-1:0]  addr = '0;
  logic [NR*DW-1:0]  wdata = '0;
  logic [NR-1:0]     gnt, rvalid;
  logic [NR*DW-1:0]  rdata;
  logic [AW-1:0]     ram_addr_a, ram_addr_b;
  logic [DW-1:0]     ram_data_a, ram_data_b, ram_out_a, ram_out_b;
  logic              ram_we_a, ram_we_b;
  logic [15:0]       conflict_cnt;

  logic [DW-1:0]     mem [0:(1<<AW)-1];
  logic              pl_en = 1'b0;
  logic [AW-1:0]     pl_addr = '0;
  logic [DW-1:0]     pl_dat = '0;

  int vectors = 0;
  int miscompares = 0;

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_out_a(ram_out_a), .ram_out_b(ram_out_b),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_out_a <= mem[ram_addr_a];
    ram_out_b <= mem[ram_addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    req = '1;
    #1;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
    vectors++; if ({ram_we_a, ram_we_b} !== 2'b00) begin miscompares++; $display("FAIL rst_we got %b exp 00", {ram_we_a, ram_we_b}); end
    vectors++; if ({ram_addr_a, ram_addr_b, ram_data_a, ram_data_b} !== '0) begin miscompares++; $display("FAIL rst_ramport got %h exp 0", {ram_addr_a, ram_addr_b, ram_data_a, ram_data_b}); end
    vectors++; if (rvalid !== 4'b0000 || rdata !== '0) begin miscompares++; $display("FAIL rst_rd got %b/%h exp 0/0", rvalid, rdata); end
    vectors++; if (conflict_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_cnt got %0d exp 0", conflict_cnt); end
    req = '0;
    pl_en = 1'b1; pl_addr = 6'd5; pl_dat = 8'h3C;
    tick();
    pl_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    drive(0, 1'b0, 6'd5, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    tick(); req = '0;
    vectors++; if (ram_addr_a !== 6'd5 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin miscompares++; $display("FAIL single_cmd got a=%0d we=%b%b exp 5 00", ram_addr_a, ram_we_a, ram_we_b); end
    vectors++; if (rvalid !== 4'b0000) begin miscompares++; $display("FAIL single_early got %b exp 0000", rvalid); end
    tick();
    vectors++; if (rvalid !== 4'b0001 || rdata[7:0] !== 8'h3C) begin miscompares++; $display("FAIL single_ret got %b/%h exp 0001/3c", rvalid, rdata[7:0]); end
    tick();
    vectors++; if (rvalid !== 4'b0000 || rdata[7:0] !== 8'h3C) begin miscompares++; $display("FAIL single_hold got %b/%h exp 0000/3c", rvalid, rdata[7:0]); end
  endtask

  // rr = 1 on entry: requester 1 lands on port A, requester 0 on port B.
  task automatic test_dual_grant();
    drive(0, 1'b1, 6'd10, 8'hA5);
    drive(1, 1'b1, 6'd20, 8'h5A);
    #1;
    vectors++; if (gnt !== 4'b0011) begin miscompares++; $display("FAIL dual_wgnt got %b exp 0011", gnt); end
    tick();
    vectors++; if ({ram_we_a, ram_we_b} !== 2'b11) begin miscompares++; $display("FAIL dual_we got %b exp 11", {ram_we_a, ram_we_b}); end
    vectors++; if (ram_addr_a !== 6'd20 || ram_data_a !== 8'h5A || ram_addr_b !== 6'd10 || ram_data_b !== 8'hA5)
      begin miscompares++; $display("FAIL dual_ports got a=%0d/%h b=%0d/%h exp 20/5a 10/a5", ram_addr_a, ram_data_a, ram_addr_b, ram_data_b); end
    drive(0, 1'b0, 6'd10, 8'h00);
    drive(1, 1'b0, 6'd20, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b0011) begin miscompares++; $display("FAIL dual_rgnt got %b exp 0011", gnt); end
    tick(); req = '0;
    tick();
    vectors++; if (rvalid !== 4'b0011 || rdata[15:0] !== 16'h5AA5) begin miscompares++; $display("FAIL dual_ret got %b/%h exp 0011/5aa5", rvalid, rdata[15:0]); end
    tick();
    // rr = 1 here; requester 3 alone leaves rr = 0
    drive(3, 1'b0, 6'd5, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL r3_gnt got %b exp 1000", gnt); end
    tick(); req = '0;
    tick();
    vectors++; if (rvalid !== 4'b1000 || rdata[31:24] !== 8'h3C) begin miscompares++; $display("FAIL r3_ret got %b/%h exp 1000/3c", rvalid, rdata[31:24]); end
    tick();
  endtask

  task automatic test_hazard();
    drive(0, 1'b1, 6'd7, 8'h11);
    drive(1, 1'b0, 6'd7, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL haz_gnt got %b exp 0001", gnt); end
    tick(); req[0] = 1'b0;
    vectors++; if (conflict_cnt !== 16'd1) begin miscompares++; $display("FAIL haz_cnt got %0d exp 1", conflict_cnt); end
    #1;
    vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL haz_retry got %b exp 0010", gnt); end
    tick(); req = '0;
    vectors++; if (ram_addr_a !== 6'd7 || ram_we_a !== 1'b0 || conflict_cnt !== 16'd1) begin miscompares++; $display("FAIL haz_cmd got a=%0d we=%b cnt=%0d exp 7 0 1", ram_addr_a, ram_we_a, conflict_cnt); end
    tick();
    vectors++; if (rvalid !== 4'b0010 || rdata[15:8] !== 8'h11) begin miscompares++; $display("FAIL haz_ret got %b/%h exp 0010/11", rvalid, rdata[15:8]); end
    tick();
  endtask

  // rr = 2: two reads to one address are both granted.
  task automatic test_same_addr_reads();
    drive(2, 1'b0, 6'd7, 8'h00);
    drive(3, 1'b0, 6'd7, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b1100) begin miscompares++; $display("FAIL rr_same_gnt got %b exp 1100", gnt); end
    tick(); req = '0;
    vectors++; if (conflict_cnt !== 16'd1) begin miscompares++; $display("FAIL rr_same_cnt got %0d exp 1", conflict_cnt); end
    tick();
    vectors++; if (rvalid !== 4'b1100 || rdata[31:16] !== 16'h1111) begin miscompares++; $display("FAIL rr_same_ret got %b/%h exp 1100/1111", rvalid, rdata[31:16]); end
    tick();
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_g, exp_v;
    drive(0, 1'b0, 6'd5, 8'h00);
    drive(1, 1'b0, 6'd10, 8'h00);
    drive(2, 1'b0, 6'd20, 8'h00);
    drive(3, 1'b0, 6'd7, 8'h00);
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req = '0;
      #1;
      exp_g = (c >= 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b0011 : 4'b1100);
      vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL fair_gnt c=%0d got %b exp %b", c, gnt, exp_g); end
      if (c >= 2) begin
        exp_v = (c % 2 == 0) ? 4'b0011 : 4'b1100;
        vectors++; if (rvalid !== exp_v) begin miscompares++; $display("FAIL fair_rv c=%0d got %b exp %b", c, rvalid, exp_v); end
      end
      tick();
    end
    vectors++; if (rvalid !== 4'b0000 || rdata !== 32'h115AA53C) begin miscompares++; $display("FAIL fair_data got %b/%h exp 0000/115aa53c", rvalid, rdata); end
  endtask

  task automatic test_wrap();
    drive(2, 1'b0, 6'd20, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL wrap_pre got %b exp 0100", gnt); end
    tick(); req = '0;
    tick();
    drive(3, 1'b0, 6'd7, 8'h00);
    drive(0, 1'b0, 6'd5, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b1001) begin miscompares++; $display("FAIL wrap_gnt got %b exp 1001", gnt); end
    tick(); req = '0;
    vectors++; if (ram_addr_a !== 6'd7 || ram_addr_b !== 6'd5) begin miscompares++; $display("FAIL wrap_ports got a=%0d b=%0d exp 7 5", ram_addr_a, ram_addr_b); end
    tick();
    vectors++; if (rvalid !== 4'b1001 || rdata[31:24] !== 8'h11 || rdata[7:0] !== 8'h3C) begin miscompares++; $display("FAIL wrap_ret got %b/%h exp 1001/11xxxx3c", rvalid, rdata); end
    drive(0, 1'b0, 6'd1, 8'h00);
    drive(1, 1'b0, 6'd2, 8'h00);
    drive(2, 1'b0, 6'd3, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b0110) begin miscompares++; $display("FAIL wrap_rr got %b exp 0110", gnt); end
    tick(); req = '0;
    tick();
    tick();
  endtask

  // rr = 3 on entry.
  task automatic test_reset_mid_read();
    drive(3, 1'b0, 6'd5, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL mid_gnt got %b exp 1000", gnt); end
    tick();
    rst = 1'b1;
    req = '1;
    #1;
    vectors++; if (gnt !== 4'b0000 || {ram_we_a, ram_we_b} !== 2'b00) begin miscompares++; $display("FAIL mid_rst_ctl got %b/%b exp 0000/00", gnt, {ram_we_a, ram_we_b}); end
    vectors++; if (ram_addr_a !== 6'd0 || ram_addr_b !== 6'd0 || conflict_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_rst_regs got a=%0d b=%0d cnt=%0d exp 0 0 0", ram_addr_a, ram_addr_b, conflict_cnt); end
    vectors++; if (rvalid !== 4'b0000 || rdata !== '0) begin miscompares++; $display("FAIL mid_rst_rd got %b/%h exp 0/0", rvalid, rdata); end
    tick();
    vectors++; if (rvalid !== 4'b0000) begin miscompares++; $display("FAIL mid_drop got %b exp 0000", rvalid); end
    tick();
    rst = 1'b0;
    req = '0;
    tick();
    vectors++; if (rvalid !== 4'b0000) begin miscompares++; $display("FAIL mid_post got %b exp 0000", rvalid); end
    drive(0, 1'b0, 6'd5, 8'h00);
    drive(1, 1'b0, 6'd7, 8'h00);
    #1;
    vectors++; if (gnt !== 4'b0011) begin miscompares++; $display("FAIL resume_gnt got %b exp 0011", gnt); end
    tick(); req = '0;
    tick();
    vectors++; if (rvalid !== 4'b0011 || rdata[15:0] !== 16'h113C) begin miscompares++; $display("FAIL resume_ret got %b/%h exp 0011/113c", rvalid, rdata[15:0]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_dual_grant();
    test_hazard();
    test_same_addr_reads();
    test_fairness();
    test_wrap();
    test_reset_mid_read();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
